// File: rtl/retire_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : retire_perf_monitor
//  Purpose  : Commit-stream monitor on the core retire port(s). Counts RUN
//             cycles and retired instructions by class across CHANNELS lanes,
//             detects end-of-test (halt instruction), retire-free hangs and a
//             global cycle timeout, and freezes its counters on termination.
//  Ports    : clk, rst (sync, active-high)
//             start_i                      begin / restart monitoring
//             ret_valid_i [CHANNELS]       lane i retires this cycle
//             ret_pc_i    [CHANNELS*XLEN]  PC of lane i
//             ret_instr_i [CHANNELS*32]    instruction word of lane i
//             ret_kind_i  [CHANNELS*2]     00 ALU, 01 load, 10 store, 11 branch
//             state_o                      00 IDLE, 01 RUN, 10 DONE, 11 FAULT
//             done_o / hung_o / timeout_o  sticky termination cause
//             cycle/instr/load/store/branch_cnt_o, max_stall_o  [CNT_W]
//             halt_pc_o [XLEN]             PC of the retiring halt
//  Revision : 1.0 - initial release
// ============================================================================
module retire_perf_monitor #(
  parameter int          XLEN        = 32,
  parameter int          CHANNELS    = 1,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] HALT_INSTR  = 32'h0000006f,
  parameter int          STALL_LIMIT = 1024,
  parameter int          MAX_CYCLES  = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CHANNELS-1:0]      ret_valid_i,
  input  logic [CHANNELS*XLEN-1:0] ret_pc_i,
  input  logic [CHANNELS*32-1:0]   ret_instr_i,
  input  logic [CHANNELS*2-1:0]    ret_kind_i,
  output logic [1:0]               state_o,
  output logic                     done_o,
  output logic                     hung_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [CNT_W-1:0]         instr_cnt_o,
  output logic [CNT_W-1:0]         load_cnt_o,
  output logic [CNT_W-1:0]         store_cnt_o,
  output logic [CNT_W-1:0]         branch_cnt_o,
  output logic [XLEN-1:0]          halt_pc_o,
  output logic [CNT_W-1:0]         max_stall_o
);

  localparam int PW = $clog2(CHANNELS + 1);
  // Limit comparisons are done at least 32 bits wide so a narrow CNT_W never
  // truncates the limit (a truncated limit of 0 would fire spuriously).
  localparam int CW = (CNT_W > 32) ? CNT_W : 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DONE  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t r_state, w_state_next;

  logic [CNT_W-1:0] r_cycle, r_instr, r_load, r_store, r_branch;
  logic [CNT_W-1:0] r_stall, r_max_stall;
  logic [XLEN-1:0]  r_halt_pc;
  logic             r_done, r_hung, r_timeout;

  logic [PW-1:0]    w_n_instr, w_n_load, w_n_store, w_n_branch;
  logic             w_halt;
  logic [XLEN-1:0]  w_halt_pc;
  logic [CNT_W-1:0] w_cycle_next, w_stall_next, w_max_next;
  logic             w_hang, w_tmo;

  // Saturating add of a small popcount onto a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Lane scan in program order: once a halt has been accepted, all younger
  // lanes are discarded. The halt lane itself is counted.
  always_comb begin
    w_n_instr  = '0;
    w_n_load   = '0;
    w_n_store  = '0;
    w_n_branch = '0;
    w_halt     = 1'b0;
    w_halt_pc  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ret_valid_i[i] && !w_halt) begin
        w_n_instr = w_n_instr + PW'(1);
        case (ret_kind_i[i*2 +: 2])
          2'b01:   w_n_load   = w_n_load + PW'(1);
          2'b10:   w_n_store  = w_n_store + PW'(1);
          2'b11:   w_n_branch = w_n_branch + PW'(1);
          default: ;
        endcase
        if (ret_instr_i[i*32 +: 32] == HALT_INSTR) begin
          w_halt    = 1'b1;
          w_halt_pc = ret_pc_i[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Any valid lane (even a discarded one) breaks a stall run.
  always_comb begin
    w_cycle_next = sat_add(r_cycle, PW'(1));
    w_stall_next = (|ret_valid_i) ? '0 : sat_add(r_stall, PW'(1));
    w_max_next   = (w_stall_next > r_max_stall) ? w_stall_next : r_max_stall;
    w_hang       = (CW'(w_stall_next) == CW'(STALL_LIMIT));
    w_tmo        = (CW'(w_cycle_next) == CW'(MAX_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_next = S_RUN;
      S_RUN: begin
        if (w_halt)               w_state_next = S_DONE;
        else if (w_hang || w_tmo) w_state_next = S_FAULT;
      end
      S_DONE,
      S_FAULT: if (start_i) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters run only in RUN; a start from any non-RUN state clears them so
  // the new RUN begins from zero.
  always_ff @(posedge clk) begin
    if (rst || ((r_state != S_RUN) && start_i)) begin
      r_cycle     <= '0;
      r_instr     <= '0;
      r_load      <= '0;
      r_store     <= '0;
      r_branch    <= '0;
      r_stall     <= '0;
      r_max_stall <= '0;
      r_halt_pc   <= '0;
      r_done      <= 1'b0;
      r_hung      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cycle     <= w_cycle_next;
      r_instr     <= sat_add(r_instr, w_n_instr);
      r_load      <= sat_add(r_load, w_n_load);
      r_store     <= sat_add(r_store, w_n_store);
      r_branch    <= sat_add(r_branch, w_n_branch);
      r_stall     <= w_stall_next;
      r_max_stall <= w_max_next;
      if (w_halt) begin
        r_done    <= 1'b1;
        r_halt_pc <= w_halt_pc;
      end else if (w_hang) begin
        r_hung    <= 1'b1;
      end else if (w_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign state_o      = r_state;
  assign done_o       = r_done;
  assign hung_o       = r_hung;
  assign timeout_o    = r_timeout;
  assign cycle_cnt_o  = r_cycle;
  assign instr_cnt_o  = r_instr;
  assign load_cnt_o   = r_load;
  assign store_cnt_o  = r_store;
  assign branch_cnt_o = r_branch;
  assign halt_pc_o    = r_halt_pc;
  assign max_stall_o  = r_max_stall;

endmodule
`default_nettype wire

// File: tb/tb_retire_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retire_perf_monitor
//  Purpose  : Self-checking bench. Instance A: CHANNELS=2, STALL_LIMIT=8,
//             MAX_CYCLES=50. Instance B: CHANNELS=1, CNT_W=4 (saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_retire_perf_monitor;

  localparam logic [31:0] I_ALU  = 32'h00000013;
  localparam logic [31:0] I_LD   = 32'h00002003;
  localparam logic [31:0] I_ST   = 32'h00002023;
  localparam logic [31:0] I_BR   = 32'h00000063;
  localparam logic [31:0] I_HALT = 32'h0000006f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic        a_start;
  logic [1:0]  a_valid;
  logic [63:0] a_pc, a_instr;
  logic [3:0]  a_kind;
  logic [1:0]  a_state;
  logic        a_done, a_hung, a_tmo;
  logic [63:0] a_cyc, a_ins, a_ld, a_st, a_br, a_mst;
  logic [31:0] a_hpc;

  // Instance B
  logic        b_start;
  logic [0:0]  b_valid;
  logic [31:0] b_pc, b_instr;
  logic [1:0]  b_kind;
  logic [1:0]  b_state;
  logic        b_done, b_hung, b_tmo;
  logic [3:0]  b_cyc, b_ins, b_ld, b_st, b_br, b_mst;
  logic [31:0] b_hpc;

  retire_perf_monitor #(.XLEN(32), .CHANNELS(2), .CNT_W(64), .HALT_INSTR(I_HALT),
                        .STALL_LIMIT(8), .MAX_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .ret_valid_i(a_valid),
    .ret_pc_i(a_pc), .ret_instr_i(a_instr), .ret_kind_i(a_kind),
    .state_o(a_state), .done_o(a_done), .hung_o(a_hung), .timeout_o(a_tmo),
    .cycle_cnt_o(a_cyc), .instr_cnt_o(a_ins), .load_cnt_o(a_ld),
    .store_cnt_o(a_st), .branch_cnt_o(a_br), .halt_pc_o(a_hpc),
    .max_stall_o(a_mst));

  retire_perf_monitor #(.XLEN(32), .CHANNELS(1), .CNT_W(4), .HALT_INSTR(I_HALT))
  dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .ret_valid_i(b_valid),
    .ret_pc_i(b_pc), .ret_instr_i(b_instr), .ret_kind_i(b_kind),
    .state_o(b_state), .done_o(b_done), .hung_o(b_hung), .timeout_o(b_tmo),
    .cycle_cnt_o(b_cyc), .instr_cnt_o(b_ins), .load_cnt_o(b_ld),
    .store_cnt_o(b_st), .branch_cnt_o(b_br), .halt_pc_o(b_hpc),
    .max_stall_o(b_mst));

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [1:0]  exp_state;
    logic [63:0] exp_instr;
  } vec_t;

  vec_t tbl[20];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive lane 0 of A, lane 1 idle.
  task automatic a_lane0(input logic v, input logic [31:0] ins,
                         input logic [1:0] k, input logic [31:0] pc);
    a_valid = {1'b0, v};
    a_instr = {32'h0, ins};
    a_kind  = {2'b00, k};
    a_pc    = {32'h0, pc};
  endtask

  task automatic a_restart();
    a_lane0(1'b0, 32'h0, 2'b00, 32'h0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  initial begin
    a_start = 1'b0; b_start = 1'b0;
    a_lane0(1'b0, 32'h0, 2'b00, 32'h0);
    b_valid = 1'b0; b_pc = '0; b_instr = '0; b_kind = '0;

    for (int i = 0; i < 20; i++) begin
      tbl[i].kind  = (i < 10) ? 2'b00 : (i < 13) ? 2'b01 : (i < 15) ? 2'b10 : 2'b11;
      tbl[i].instr = (i < 10) ? I_ALU : (i < 13) ? I_LD : (i < 15) ? I_ST : I_BR;
      tbl[i].pc    = 32'h80000000 + 32'(4 * i);
      tbl[i].exp_state = 2'b01;
      tbl[i].exp_instr = 64'(i + 1);
    end
    tbl[19].instr     = I_HALT;
    tbl[19].pc        = 32'h80000040;
    tbl[19].exp_state = 2'b10;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_state", 64'(a_state), 64'd0);
    chk("rst_cyc", a_cyc, 64'd0);
    chk("rst_flags", {61'd0, a_done, a_hung, a_tmo}, 64'd0);
    chk("rst_b_state", 64'(b_state), 64'd0);

    // IDLE ignores retires
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    step();
    chk("idle_state", 64'(a_state), 64'd0);
    chk("idle_instr", a_ins, 64'd0);

    // Single-lane program ending in halt
    a_restart();
    chk("start_state", 64'(a_state), 64'd1);
    chk("start_cyc", a_cyc, 64'd0);
    for (int i = 0; i < 20; i++) begin
      a_lane0(1'b1, tbl[i].instr, tbl[i].kind, tbl[i].pc);
      step();
      chk("t1_state", 64'(a_state), 64'(tbl[i].exp_state));
      chk("t1_instr", a_ins, tbl[i].exp_instr);
    end
    chk("t1_load", a_ld, 64'd3);
    chk("t1_store", a_st, 64'd2);
    chk("t1_branch", a_br, 64'd5);
    chk("t1_cycle", a_cyc, 64'd20);
    chk("t1_hpc", 64'(a_hpc), 64'h80000040);
    chk("t1_done", 64'(a_done), 64'd1);

    // DONE freezes counters
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    step(); step();
    chk("frz_state", 64'(a_state), 64'd2);
    chk("frz_instr", a_ins, 64'd20);
    chk("frz_cycle", a_cyc, 64'd20);

    // Two lanes: halt on lane 0 discards younger load on lane 1
    a_restart();
    chk("rs_instr", a_ins, 64'd0);
    chk("rs_done", 64'(a_done), 64'd0);
    chk("rs_hpc", 64'(a_hpc), 64'd0);
    a_valid = 2'b11; a_instr = {I_LD, I_HALT}; a_kind = 4'b0111;
    a_pc = {32'h00000204, 32'h00000200};
    step();
    chk("l0h_instr", a_ins, 64'd1);
    chk("l0h_load", a_ld, 64'd0);
    chk("l0h_done", 64'(a_done), 64'd1);
    chk("l0h_hpc", 64'(a_hpc), 64'h200);
    chk("l0h_state", 64'(a_state), 64'd2);

    // Two lanes: older load counted, halt on lane 1
    a_restart();
    a_valid = 2'b11; a_instr = {I_HALT, I_LD}; a_kind = 4'b1101;
    a_pc = {32'h00000304, 32'h00000300};
    step();
    chk("l1h_instr", a_ins, 64'd2);
    chk("l1h_load", a_ld, 64'd1);
    chk("l1h_hpc", 64'(a_hpc), 64'h304);

    // Hang: 2 retires then 8 empty cycles
    a_restart();
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    step(); step();
    a_lane0(1'b0, 32'h0, 2'b00, 32'h0);
    for (int i = 0; i < 7; i++) step();
    chk("hang7_state", 64'(a_state), 64'd1);
    chk("hang7_hung", 64'(a_hung), 64'd0);
    step();
    chk("hang_state", 64'(a_state), 64'd3);
    chk("hang_hung", 64'(a_hung), 64'd1);
    chk("hang_other", {62'd0, a_done, a_tmo}, 64'd0);
    chk("hang_mst", a_mst, 64'd8);
    chk("hang_cyc", a_cyc, 64'd10);
    chk("hang_instr", a_ins, 64'd2);

    // Timeout after 50 RUN cycles of continuous ALU retire
    a_restart();
    chk("rs_mst", a_mst, 64'd0);
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    for (int i = 0; i < 49; i++) step();
    chk("tmo49_state", 64'(a_state), 64'd1);
    step();
    chk("tmo_state", 64'(a_state), 64'd3);
    chk("tmo_flag", 64'(a_tmo), 64'd1);
    chk("tmo_hung", 64'(a_hung), 64'd0);
    chk("tmo_cyc", a_cyc, 64'd50);
    chk("tmo_instr", a_ins, 64'd50);

    // Halt on the timeout cycle wins
    a_restart();
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    for (int i = 0; i < 49; i++) step();
    a_lane0(1'b1, I_HALT, 2'b11, 32'h00000500);
    step();
    chk("ht_state", 64'(a_state), 64'd2);
    chk("ht_done", 64'(a_done), 64'd1);
    chk("ht_tmo", 64'(a_tmo), 64'd0);
    chk("ht_cyc", a_cyc, 64'd50);

    // Reset mid-RUN beats start and halt
    a_restart();
    a_lane0(1'b1, I_ALU, 2'b00, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_instr", a_ins, 64'd5);
    rst = 1'b1; a_start = 1'b1;
    a_lane0(1'b1, I_HALT, 2'b11, 32'h00000600);
    step();
    chk("mrst_state", 64'(a_state), 64'd0);
    chk("mrst_instr", a_ins, 64'd0);
    chk("mrst_cyc", a_cyc, 64'd0);
    chk("mrst_flags", {61'd0, a_done, a_hung, a_tmo}, 64'd0);
    chk("mrst_hpc", 64'(a_hpc), 64'd0);
    rst = 1'b0; a_start = 1'b0;
    a_lane0(1'b0, 32'h0, 2'b00, 32'h0);

    // CNT_W=4 saturation on instance B
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_valid = 1'b1; b_instr = I_ALU; b_kind = 2'b00;
    for (int i = 0; i < 20; i++) step();
    chk("sat_instr", 64'(b_ins), 64'd15);
    chk("sat_cyc", 64'(b_cyc), 64'd15);
    chk("sat_state", 64'(b_state), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
